ncl_gate_test_sequencer: RTL
============================

Name: ncl_gate_test_sequencer

Overview:
Synthesisable controller that runs one complete check of an NCL gate pair: a reference model and the gate under test. Both gates receive the same stimulus. On a request it does three things in order:
- applies the gate reset;
- sweeps every input vector, ascending then descending, so that threshold-gate hysteresis is exercised;
- compares the two outputs after a settle window, counts mismatches, then pulses a grant.
It replaces free-running stimulus plus bench-side comparison with one cycle-exact sequencer shared by all gate benches.

Parameters:
INPUT_PORTS, 3, number of gate data inputs (1..8).
RESET_PORT, 1, 0: gate has no reset; the RESET phase is skipped and rsb is held deasserted.
RESET_SENS, 0, rsb polarity. 0: active low; 1: active high.
RESET_CYCLES, 4, number of cycles rsb is asserted in the RESET phase (>=1).
SETTLE_CYCLES, 2, number of cycles each vector is held before comparison (>=1).
ERR_W, 16, width of the error counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  1  start request, sampled only in IDLE
y_ref  in  1  reference gate output
y  in  1  gate-under-test output
stm_value  out  INPUT_PORTS  registered stimulus vector to both gates
rsb  out  1  registered gate reset, polarity set by RESET_SENS
busy  out  1  high from req acceptance through DONE inclusive
gnt  out  1  one-cycle completion pulse
pass  out  1  valid when gnt=1 and held until next start; 1 if error_cnt==0
error_cnt  out  ERR_W  mismatch count for the current/last run, saturating
vec_idx  out  INPUT_PORTS+1  index of the vector currently applied

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On rst:
  - state=IDLE, stm_value=0, rsb=~RESET_SENS (deasserted), busy=0, gnt=0, pass=0, error_cnt=0, vec_idx=0.
  - rst asserted mid-run aborts at once to these values; no gnt is issued.
- States: IDLE, RESET, SETTLE, CHECK, DONE.
- IDLE:
  - req=1 -> clear error_cnt, pass and vec_idx; stm_value=0.
  - Go to RESET if RESET_PORT=1, else to SETTLE with vector 0.
  - req while not in IDLE is ignored; it is not queued.
- RESET: rsb=RESET_SENS for exactly RESET_CYCLES cycles, stm_value=0. Then rsb is deasserted and the block enters SETTLE with vector 0 applied.
- Vector order: N=2^INPUT_PORTS, total 2N vectors.
  - vec_idx k<N: stm_value=k.
  - vec_idx k>=N: stm_value=2N-1-k, i.e. N-1 down to 0.
- SETTLE: stm_value is registered on entry and held for SETTLE_CYCLES cycles, then the block moves to CHECK.
- CHECK (1 cycle):
  - Compare y_ref against y with case inequality, so X/Z on either side counts as a mismatch.
  - On mismatch, error_cnt increments; it saturates at 2^ERR_W-1.
  - If vec_idx==2N-1 -> DONE; else vec_idx+1 and back to SETTLE.
- DONE (1 cycle): gnt=1, pass=(error_cnt==0), busy=1, then IDLE. stm_value and rsb hold their last values.
- Latency: req sampled at edge 0 -> gnt high during cycle RESET_PORT*RESET_CYCLES + 2N*(SETTLE_CYCLES+1) + 1.
  - Defaults: cycle 53.
- error_cnt, pass and vec_idx hold after DONE until the next accepted req.

Optional Feature:
Macro NCL_SEQ_ABORT_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. error_cnt=1, vec_idx is frozen at the failing index, and pass=0.
- Undefined: the full sweep always completes and every mismatch is counted.

Test Plan:
- Defaults, y tied to y_ref (th33r pair) -> gnt exactly one cycle, 53 cycles after req; pass=1, error_cnt=0; rsb low for cycles 1-4 only.
- Defaults, y stuck 0, y_ref from correct th33r -> failures at ascending vector 7 and descending vectors 7..1 (hysteresis hold), giving error_cnt=8, pass=0.
- Same as above with NCL_SEQ_ABORT_EN defined -> gnt at cycle 4+8*3+1=29, error_cnt=1, vec_idx=7, pass=0.
- RESET_PORT=0, INPUT_PORTS=2, y=y_ref -> rsb constantly 1, no RESET phase; gnt at cycle 8*3+1=25; stm_value sequence 0,1,2,3,3,2,1,0.
- rst asserted at cycle 20 of a run, then req again -> all outputs return to reset values with no gnt; the second run completes normally with gnt at cycle 53 after its req.
- req held high throughout, plus a req pulse mid-run -> no restart mid-run; a new run starts only on the cycle after DONE returns to IDLE with req=1.

Source files
------------

// File: rtl/ncl_gate_test_sequencer_if.sv
// Handshake/stimulus bundle between the NCL gate test sequencer and the gate pair.
// The master modport is the sequencer side.
interface ncl_gate_test_sequencer_if #(
  parameter int INPUT_PORTS = 3,
  parameter int ERR_W       = 16
);
  logic                   req;
  logic                   y_ref;
  logic                   y;
  logic [INPUT_PORTS-1:0] stm_value;
  logic                   rsb;
  logic                   busy;
  logic                   gnt;
  logic                   pass;
  logic [ERR_W-1:0]       error_cnt;
  logic [INPUT_PORTS:0]   vec_idx;

  modport master (
    input  req, y_ref, y,
    output stm_value, rsb, busy, gnt, pass, error_cnt, vec_idx
  );

  modport slave (
    output req, y_ref, y,
    input  stm_value, rsb, busy, gnt, pass, error_cnt, vec_idx
  );
endinterface

// File: rtl/ncl_gate_test_sequencer.sv
// Cycle-exact reset / up-down sweep / compare sequencer for an NCL reference-vs-DUT gate pair.
// Optional: define NCL_SEQ_ABORT_EN to stop the sweep at the first mismatch.
module ncl_gate_test_sequencer #(
  parameter int INPUT_PORTS   = 3,
  parameter int RESET_PORT    = 1,
  parameter int RESET_SENS    = 0,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 16
) (
  input logic                       clk,
  input logic                       rst,
  ncl_gate_test_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]     RST_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SET_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic                 RSB_ON   = (RESET_SENS != 0);
  localparam logic                 RSB_OFF  = ~RSB_ON;
  localparam logic [INPUT_PORTS:0] LAST_IDX = '1;
  localparam logic [ERR_W-1:0]     ERR_MAX  = '1;

`ifdef NCL_SEQ_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INPUT_PORTS-1:0] stm_value_q, stm_value_d;
  logic                   rsb_q, rsb_d;
  logic                   busy_q, busy_d;
  logic                   gnt_q, gnt_d;
  logic                   pass_q, pass_d;
  logic [ERR_W-1:0]       error_cnt_q, error_cnt_d;
  logic [INPUT_PORTS:0]   vec_idx_q, vec_idx_d;
  logic                   mismatch;

  // Upper half of the index walks back down: 2N-1-k == bitwise NOT of the low bits.
  function automatic logic [INPUT_PORTS-1:0] vec_to_stm(input logic [INPUT_PORTS:0] k);
    return k[INPUT_PORTS] ? ~k[INPUT_PORTS-1:0] : k[INPUT_PORTS-1:0];
  endfunction

  // Case inequality so an X/Z on either gate output is scored as a failure.
  assign mismatch = (bus.y_ref !== bus.y);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stm_value_d = stm_value_q;
    rsb_d       = rsb_q;
    busy_d      = busy_q;
    gnt_d       = 1'b0;
    pass_d      = pass_q;
    error_cnt_d = error_cnt_q;
    vec_idx_d   = vec_idx_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          error_cnt_d = '0;
          pass_d      = 1'b0;
          vec_idx_d   = '0;
          stm_value_d = '0;
          busy_d      = 1'b1;
          if (RESET_PORT != 0) begin
            state_d = S_RESET;
            rsb_d   = RSB_ON;
            cnt_d   = RST_LOAD;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = SET_LOAD;
          end
        end
      end

      S_RESET: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          rsb_d   = RSB_OFF;
          cnt_d   = SET_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch && (error_cnt_q != ERR_MAX)) begin
          error_cnt_d = error_cnt_q + ERR_W'(1);
        end
        // pass reflects the count including this final comparison
        if ((ABORT_EN && mismatch) || (vec_idx_q == LAST_IDX)) begin
          state_d = S_DONE;
          gnt_d   = 1'b1;
          pass_d  = (error_cnt_d == '0);
        end else begin
          state_d     = S_SETTLE;
          vec_idx_d   = vec_idx_q + (INPUT_PORTS + 1)'(1);
          stm_value_d = vec_to_stm(vec_idx_d);
          cnt_d       = SET_LOAD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stm_value_q <= '0;
      rsb_q       <= RSB_OFF;
      busy_q      <= 1'b0;
      gnt_q       <= 1'b0;
      pass_q      <= 1'b0;
      error_cnt_q <= '0;
      vec_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stm_value_q <= stm_value_d;
      rsb_q       <= rsb_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      pass_q      <= pass_d;
      error_cnt_q <= error_cnt_d;
      vec_idx_q   <= vec_idx_d;
    end
  end

  assign bus.stm_value = stm_value_q;
  assign bus.rsb       = rsb_q;
  assign bus.busy      = busy_q;
  assign bus.gnt       = gnt_q;
  assign bus.pass      = pass_q;
  assign bus.error_cnt = error_cnt_q;
  assign bus.vec_idx   = vec_idx_q;

endmodule
